// File: rtl/alu_seq.sv
// alu_seq: registered ALU execution unit with start/busy/done handshake.
// Single-cycle ops (MOV..DEC) complete in the cycle after acceptance;
// shifts and rotates iterate one bit position per clock.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; single-cycle ops complete from here
// SHIFT | shifting work register one position per clock until cnt==0
module alu_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               c_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               c_flag,
  output logic               z_flag,
  output logic               n_flag,
  output logic               v_flag
);

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_ADC = 4'd3;
  localparam logic [3:0] OP_SBB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;
  localparam logic [3:0] OP_DEC = 4'd10;
  localparam logic [3:0] OP_SLL = 4'd11;
  localparam logic [3:0] OP_SLA = 4'd12;
  localparam logic [3:0] OP_SRL = 4'd13;
  localparam logic [3:0] OP_SRA = 4'd14;

  localparam int MSB = WIDTH - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               sc_q, sv_q;

  logic               is_shift;
  logic               is_sub;
  logic               cin_eff;
  logic [WIDTH-1:0]   opnd_b;
  logic [WIDTH:0]     arith;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [WIDTH-1:0]   step_work;
  logic               step_out;

  assign is_shift = (op > OP_DEC);
  assign busy     = (state_q == SHIFT);

  // Single-cycle datapath: WIDTH+1 bit add/subtract plus logic ops.
  always_comb begin
    opnd_b  = b;
    cin_eff = 1'b0;
    is_sub  = 1'b0;
    alu_res = a;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    if (op == OP_INC || op == OP_DEC) opnd_b = {{(WIDTH-1){1'b0}}, 1'b1};
    if (op == OP_ADC || op == OP_SBB) cin_eff = c_in;
    if (op == OP_SUB || op == OP_SBB || op == OP_DEC) is_sub = 1'b1;
    if (is_sub)
      arith = {1'b0, a} - {1'b0, opnd_b} - {{WIDTH{1'b0}}, cin_eff};
    else
      arith = {1'b0, a} + {1'b0, opnd_b} + {{WIDTH{1'b0}}, cin_eff};
    case (op)
      OP_MOV: alu_res = a;
      OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_INC, OP_DEC: begin
        alu_res = arith[WIDTH-1:0];
        // for subtraction the top bit is the borrow, not a carry
        alu_c   = arith[WIDTH];
        if (is_sub)
          alu_v = (a[MSB] != opnd_b[MSB]) && (arith[MSB] != a[MSB]);
        else
          alu_v = (a[MSB] == opnd_b[MSB]) && (arith[MSB] != a[MSB]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      default: alu_res = a;
    endcase
  end

  // One-position shift/rotate step of the work register.
  always_comb begin
    step_work = work_q;
    step_out  = 1'b0;
    case (op_q)
      OP_SLL, OP_SLA: begin
        step_work = {work_q[WIDTH-2:0], 1'b0};
        step_out  = work_q[MSB];
      end
      OP_SRL: begin
        step_work = {1'b0, work_q[WIDTH-1:1]};
        step_out  = work_q[0];
      end
      OP_SRA: begin
        step_work = {work_q[MSB], work_q[WIDTH-1:1]};
        step_out  = work_q[0];
      end
      default: begin
        step_work = {work_q[0], work_q[WIDTH-1:1]};
        step_out  = work_q[0];
      end
    endcase
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && is_shift) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, shift iteration, and registered result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_MOV;
      work_q <= '0;
      cnt_q  <= '0;
      sc_q   <= 1'b0;
      sv_q   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
      v_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_shift) begin
              op_q   <= op;
              work_q <= a;
              cnt_q  <= shamt;
              sc_q   <= 1'b0;
              sv_q   <= 1'b0;
            end else begin
              result <= alu_res;
              c_flag <= alu_c;
              v_flag <= alu_v;
              z_flag <= (alu_res == '0);
              n_flag <= alu_res[MSB];
              done   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            work_q <= step_work;
            cnt_q  <= cnt_q - SHAMT_W'(1);
            sc_q   <= step_out;
            // SLA overflow is sticky: any step that flips the sign bit
            if (op_q == OP_SLA && step_work[MSB] != work_q[MSB]) sv_q <= 1'b1;
          end else begin
            result <= work_q;
            c_flag <= sc_q;
            v_flag <= sv_q;
            z_flag <= (work_q == '0);
            n_flag <= work_q[MSB];
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: scoreboard of expected results checked on done.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        c_in;
  logic [3:0]  shamt;
  logic        busy, done;
  logic [15:0] result;
  logic        c_flag, z_flag, n_flag, v_flag;

  alu_seq #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .c_in(c_in), .shamt(shamt), .busy(busy), .done(done), .result(result),
    .c_flag(c_flag), .z_flag(z_flag), .n_flag(n_flag), .v_flag(v_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  cznv;
    int          acc;
    int          exp_cyc;
    int          sh;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic [3:0] s);
    exp_t        e;
    int          ux, uy, full, sx, sy, sfull;
    logic [15:0] r, w, nw;
    logic        c, v;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    c = 1'b0; v = 1'b0; r = x; full = 0; sfull = 0;
    case (o)
      4'd0: r = x;
      4'd1: begin full = ux + uy;      sfull = sx + sy; end
      4'd2: begin full = ux - uy;      sfull = sx - sy; c = (uy > ux); end
      4'd3: begin full = ux + uy + ci; sfull = sx + sy + ci; end
      4'd4: begin full = ux - uy - ci; sfull = sx - sy - ci; c = (uy + ci > ux); end
      4'd5: r = x & y;
      4'd6: r = x | y;
      4'd7: r = x ^ y;
      4'd8: r = ~x;
      4'd9: begin full = ux + 1; sfull = sx + 1; end
      4'd10: begin full = ux - 1; sfull = sx - 1; c = (ux == 0); end
      default: begin
        w = x;
        for (int i = 0; i < s; i++) begin
          case (o)
            4'd11, 4'd12: begin c = w[15]; nw = {w[14:0], 1'b0}; end
            4'd13: begin c = w[0]; nw = {1'b0, w[15:1]}; end
            4'd14: begin c = w[0]; nw = {w[15], w[15:1]}; end
            default: begin c = w[0]; nw = {w[0], w[15:1]}; end
          endcase
          if (o == 4'd12 && nw[15] != w[15]) v = 1'b1;
          w = nw;
        end
        r = w;
      end
    endcase
    if (o inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10}) begin
      r = full[15:0];
      if (o inside {4'd1, 4'd3, 4'd9}) c = (full > 32'h0000_FFFF);
      v = (sfull > 32767) || (sfull < -32768);
    end
    e.res  = r;
    e.cznv = {c, (r == 16'h0), r[15], v};
    e.acc = 0; e.exp_cyc = 0; e.sh = -1;
    return e;
  endfunction

  // Drive a request; returns in c1 (or the done cycle of a shift when wait_done).
  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input logic [3:0] s, input bit wait_done);
    exp_t e;
    e = model(o, x, y, ci, s);
    op = o; a = x; b = y; c_in = ci; shamt = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.acc = cyc;
    if (o > 4'd10) begin
      e.sh = s;
      e.exp_cyc = cyc + s + 1;
    end else begin
      e.exp_cyc = cyc;
    end
    sb.push_back(e);
    if (wait_done && o > 4'd10)
      repeat (s + 1) begin @(posedge clk); #1; end
  endtask

  // Output monitor: busy window, done timing, result and flags.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_busy;
      exp_t e;
      exp_busy = (sb.size() > 0) && (sb[0].sh >= 0) &&
                 (cyc >= sb[0].acc) && (cyc <= sb[0].acc + sb[0].sh);
      check("busy", busy, exp_busy);
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", done, 1'b0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.exp_cyc);
          check("result", result, e.res);
          check("flags_cznv", {c_flag, z_flag, n_flag, v_flag}, e.cznv);
        end
      end else if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
        check("late_done", done, 1'b1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 4'd0; a = 16'h0; b = 16'h0; c_in = 1'b0; shamt = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 16'h0);
    check("rst_flags", {c_flag, z_flag, n_flag, v_flag}, 4'b0000);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(4'd1, 16'h7FFF, 16'h0001, 1'b0, 4'd0, 1'b1);
    check("add_done", done, 1'b1);
    check("add_res", result, 16'h8000);
    check("add_cznv", {c_flag, z_flag, n_flag, v_flag}, 4'b0011);

    issue(4'd3, 16'hFFFF, 16'h0000, 1'b1, 4'd0, 1'b1);
    check("adc_res", result, 16'h0000);
    check("adc_czv", {c_flag, z_flag, v_flag}, 3'b110);

    issue(4'd2, 16'h0000, 16'h0001, 1'b0, 4'd0, 1'b1);
    check("sub_res", result, 16'hFFFF);
    check("sub_cn", {c_flag, n_flag}, 2'b11);

    issue(4'd14, 16'h8001, 16'h0000, 1'b0, 4'd4, 1'b1);
    check("sra_res", result, 16'hF800);
    check("sra_cn", {c_flag, n_flag}, 2'b01);

    issue(4'd13, 16'h8001, 16'h0000, 1'b0, 4'd4, 1'b1);
    check("srl_res", result, 16'h0800);

    issue(4'd15, 16'h0001, 16'h0000, 1'b0, 4'd1, 1'b1);
    check("ror_res", result, 16'h8000);
    check("ror_c", c_flag, 1'b1);

    issue(4'd12, 16'h4000, 16'h0000, 1'b0, 4'd1, 1'b1);
    check("sla_res", result, 16'h8000);
    check("sla_v", v_flag, 1'b1);

    issue(4'd11, 16'h1234, 16'h0000, 1'b0, 4'd0, 1'b1);
    check("sh0_res", result, 16'h1234);

    // back-to-back single-cycle ops
    issue(4'd1, 16'h0001, 16'h0002, 1'b0, 4'd0, 1'b0);
    issue(4'd1, 16'h0010, 16'h0020, 1'b0, 4'd0, 1'b0);
    check("b2b_res", result, 16'h0030);

    // start during a shift is ignored; operands changed mid-shift
    issue(4'd13, 16'hF0F0, 16'h0000, 1'b0, 4'd6, 1'b0);
    op = 4'd1; a = 16'h0001; b = 16'h0001; shamt = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("ign_done", done, 1'b1);
    check("ign_res", result, 16'h03C3);

    // reset mid-shift
    issue(4'd13, 16'hABCD, 16'h0000, 1'b0, 4'd10, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_result", result, 16'h0);
    check("abort_flags", {c_flag, z_flag, n_flag, v_flag}, 4'b0000);
    repeat (14) begin @(posedge clk); #1; end
    issue(4'd9, 16'hFFFF, 16'h0000, 1'b0, 4'd0, 1'b1);
    check("post_rst_res", result, 16'h0000);
    check("post_rst_cz", {c_flag, z_flag}, 2'b11);

    for (int i = 0; i < 60; i++)
      issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);

    repeat (3) begin @(posedge clk); #1; end
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
